axi4lite_reg_slave: RTL and testbench

//  Synthesizable AXI4-Lite responder: bank of NUM_REGS RW registers at BASE_ADDR, driven by an
//  AXI4-Lite master (CPU or bench master BFM). Register contents are exported to fabric, with
//  per-register write pulses. Independent read and write channels, one outstanding txn each.

---
 rtl/axi4lite_reg_slave.sv | 188 ++++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS read/write registers of 8*N bits at BASE_ADDR,
// exported flat to fabric with a one-cycle write pulse per register.
module axi4lite_reg_slave #(
    parameter int          N         = 4,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [31:0]                AWADDR,
    input  logic [2:0]                 AWPROT,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [8*N-1:0]             WDATA,
    input  logic [N-1:0]               WSTRB,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [31:0]                ARADDR,
    input  logic [2:0]                 ARPROT,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [8*N-1:0]             RDATA,
    output logic [1:0]                 RRESP,
    output logic [NUM_REGS*8*N-1:0]    regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);
    localparam int          DW   = 8 * N;
    localparam int          AL   = $clog2(N);
    localparam int          IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * N);

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_RESP } rd_state_t;

    wr_state_t             r_wr_state;
    rd_state_t             r_rd_state;
    logic                  r_awready, r_wready, r_bvalid;
    logic                  r_aw_full, r_w_full;
    logic [31:0]           r_awaddr;
    logic [DW-1:0]         r_wdata;
    logic [N-1:0]          r_wstrb;
    logic [1:0]            r_bresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_arready, r_rvalid;
    logic [DW-1:0]         r_rdata;
    logic [1:0]            r_rresp;

    logic [NUM_REGS*DW-1:0] w_regs_flat;
    logic [31:0]           w_wr_off, w_rd_off;
    logic                  w_wr_ok, w_rd_ok, w_commit;
    logic [IW-1:0]         w_wr_idx, w_rd_idx;
    logic                  w_unused;

    assign w_unused = ^{AWPROT, ARPROT};

    // Offsets wrap for addresses below BASE_ADDR, so one compare catches both sides.
    assign w_wr_off = r_awaddr - BASE_ADDR;
    assign w_wr_ok  = w_wr_off < SPAN;
    assign w_wr_idx = w_wr_off[AL +: IW];
    assign w_rd_off = ARADDR - BASE_ADDR;
    assign w_rd_ok  = w_rd_off < SPAN;
    assign w_rd_idx = w_rd_off[AL +: IW];

    assign w_commit = (r_wr_state == WR_IDLE) && r_aw_full && r_w_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DW-1:0] r_reg;
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_reg <= '0;
                end else if (w_commit && w_wr_ok && (w_wr_idx == IW'(gi))) begin
                    for (int b = 0; b < N; b++) begin
                        if (r_wstrb[b]) begin
                            r_reg[8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
            assign w_regs_flat[gi*DW +: DW] = r_reg;
        end
    endgenerate

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_commit) begin
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_ok ? 2'b00 : 2'b11;
                        if (w_wr_ok) begin
                            r_wr_pulse[w_wr_idx] <= 1'b1;
                        end
                        r_aw_full  <= 1'b0;
                        r_w_full   <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_wr_state <= WR_RESP;
                    end else begin
                        // Each channel latches independently; a full latch holds its ready low.
                        if (AWVALID && r_awready) begin
                            r_aw_full <= 1'b1;
                            r_awaddr  <= AWADDR;
                        end
                        if (WVALID && r_wready) begin
                            r_w_full <= 1'b1;
                            r_wdata  <= WDATA;
                            r_wstrb  <= WSTRB;
                        end
                        r_awready <= !(r_aw_full || (AWVALID && r_awready));
                        r_wready  <= !(r_w_full || (WVALID && r_wready));
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (ARVALID && r_arready) begin
                        // Sampled before any same-edge write lands, so a colliding read sees the old value.
                        r_rdata    <= w_rd_ok ? w_regs_flat[int'(w_rd_idx)*DW +: DW] : '0;
                        r_rresp    <= w_rd_ok ? 2'b00 : 2'b11;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_state <= RD_RESP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    assign AWREADY    = r_awready;
    assign WREADY     = r_wready;
    assign BVALID     = r_bvalid;
    assign BRESP      = r_bresp;
    assign ARREADY    = r_arready;
    assign RVALID     = r_rvalid;
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign regs_o     = w_regs_flat;
    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave: directed vector table, hand-written
// collision/reset sequences and randomized traffic against an array model.
module tb_axi4lite_reg_slave;
    localparam int          N    = 4;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h0;

    logic          ACLK, ARESET;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]   AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]    AWPROT, ARPROT;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic [511:0]  regs_o;
    logic [15:0]   wr_pulse_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_regs [NR];

    axi4lite_reg_slave #(.N(N), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE) < 32'(NR * N);
    endfunction

    function automatic int reg_index(input logic [31:0] a);
        return int'((a - BASE) / 32'(N));
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < NR; k++) f[k*32 +: 32] = model_regs[k];
        return f;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_regs[reg_index(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Full write transaction; every sample point is 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold,
                             input logic [1:0] exp_resp, input string tag);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc, lat, pulse_cnt, viol;
        logic [15:0] pulse_or, exp_pulse;
        logic [1:0] resp0;
        aw_done = 0; w_done = 0; cyc = 0; pulse_cnt = 0; pulse_or = '0; viol = 0;
        BREADY = (b_hold == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            AWVALID = !aw_done && (cyc >= aw_dly); AWADDR = addr;
            WVALID  = !w_done && (cyc >= w_dly);   WDATA = data; WSTRB = strb;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            if ((aw_done && AWREADY) || (w_done && WREADY) || BVALID) viol++;
            tick();
            if (|wr_pulse_o) pulse_cnt++;
            pulse_or |= wr_pulse_o;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        AWVALID = 0; WVALID = 0;
        chk({tag, " aw_w_handshake"}, 512'({aw_done, w_done}), 512'(2'b11));
        lat = 0;
        while (!BVALID && lat < 20) begin
            if (AWREADY || WREADY) viol++;
            tick();
            if (|wr_pulse_o) pulse_cnt++;
            pulse_or |= wr_pulse_o;
            lat++;
        end
        chk({tag, " b_latency"}, 512'(lat), 512'(1));
        chk({tag, " bresp"}, 512'(BRESP), 512'(exp_resp));
        model_write(addr, data, strb);
        chk({tag, " regs"}, regs_o, model_flat());
        resp0 = BRESP;
        for (int h = 0; h < b_hold; h++) begin
            if (!BVALID || BRESP !== resp0 || AWREADY || WREADY) viol++;
            tick();
            if (|wr_pulse_o) pulse_cnt++;
            pulse_or |= wr_pulse_o;
        end
        BREADY = 1;
        tick();
        if (|wr_pulse_o) pulse_cnt++;
        pulse_or |= wr_pulse_o;
        if (BVALID || !AWREADY || !WREADY) viol++;
        BREADY = 0;
        exp_pulse = in_range(addr) ? (16'h1 << reg_index(addr)) : 16'h0;
        chk({tag, " pulse_count"}, 512'(pulse_cnt), 512'(in_range(addr) ? 1 : 0));
        chk({tag, " pulse_mask"}, 512'(pulse_or), 512'(exp_pulse));
        chk({tag, " wr_protocol"}, 512'(viol), 512'(0));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
        bit done, hs;
        int cyc, viol;
        logic [31:0] d0;
        logic [1:0] r0;
        done = 0; cyc = 0; viol = 0;
        RREADY = (r_hold == 0);
        while (!done && cyc < 40) begin
            ARVALID = (cyc >= ar_dly); ARADDR = addr;
            hs = ARVALID && ARREADY;
            if (RVALID) viol++;
            tick();
            if (hs) done = 1;
            cyc++;
        end
        ARVALID = 0;
        chk({tag, " ar_handshake"}, 512'(done), 512'(1));
        chk({tag, " rvalid_latency"}, 512'(RVALID), 512'(1));
        chk({tag, " rdata"}, 512'(RDATA), 512'(exp_data));
        chk({tag, " rresp"}, 512'(RRESP), 512'(exp_resp));
        d0 = RDATA; r0 = RRESP;
        for (int h = 0; h < r_hold; h++) begin
            if (!RVALID || RDATA !== d0 || RRESP !== r0 || ARREADY) viol++;
            tick();
        end
        RREADY = 1;
        tick();
        if (RVALID || !ARREADY) viol++;
        RREADY = 0;
        chk({tag, " rd_protocol"}, 512'(viol), 512'(0));
    endtask

    task automatic read_model(input logic [31:0] addr, input int ar_dly, input int r_hold, input string tag);
        axi_read(addr, ar_dly, r_hold, in_range(addr) ? model_regs[reg_index(addr)] : 32'h0,
                 in_range(addr) ? 2'b00 : 2'b11, tag);
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  aw_dly;
        logic [3:0]  w_dly;
        logic [3:0]  hold;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] old1, a, d;
        logic [3:0] s;
        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,       4'h0, 4'd0, 4'd0, 4'd0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h08, 32'h00005500, 4'h2, 4'd3, 4'd0, 4'd0, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h08, 32'h0,       4'h0, 4'd0, 4'd0, 4'd0, 2'b00, 32'hDEAD55EF};
        vecs[4]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 4'd0, 4'd0, 4'd0, 2'b11, 32'h0};
        vecs[5]  = '{1'b0, 32'h40, 32'h0,       4'h0, 4'd0, 4'd0, 4'd0, 2'b11, 32'h0};
        vecs[6]  = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'h9, 4'd0, 4'd2, 4'd5, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h3C, 32'h0,       4'h0, 4'd1, 4'd0, 4'd5, 2'b00, 32'hA50000A5};
        vecs[8]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 4'd2, 4'd0, 4'd0, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h02, 32'h0,       4'h0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h11223344};
        vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 4'd0, 4'd0, 4'd0, 2'b11, 32'h0};
        vecs[11] = '{1'b1, 32'h0B, 32'h00000077, 4'h1, 4'd1, 4'd1, 4'd0, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h08, 32'h0,       4'h0, 4'd0, 4'd0, 4'd0, 2'b00, 32'hDEAD5577};

        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
        ARESET = 1; AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; AWPROT = 0; ARPROT = 0;

        // Reset state, then readies come up one edge after release.
        tick(); tick();
        chk("reset valids", 512'({BVALID, RVALID, |wr_pulse_o}), 512'(0));
        chk("reset readies", 512'({AWREADY, WREADY, ARREADY}), 512'(0));
        chk("reset regs", regs_o, 512'(0));
        chk("reset resp_data", 512'({BRESP, RRESP, RDATA}), 512'(0));
        ARESET = 0;
        #1;
        chk("readies before first edge", 512'({AWREADY, WREADY, ARREADY}), 512'(0));
        tick();
        chk("readies after first edge", 512'({AWREADY, WREADY, ARREADY}), 512'(3'b111));

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, int'(vecs[i].aw_dly),
                          int'(vecs[i].w_dly), int'(vecs[i].hold), vecs[i].resp, $sformatf("vec%0d", i));
            else
                axi_read(vecs[i].addr, int'(vecs[i].aw_dly), int'(vecs[i].hold), vecs[i].rdata,
                         vecs[i].resp, $sformatf("vec%0d", i));
        end

        // Read handshake on the write-commit edge of the same register sees the old value.
        old1 = model_regs[1];
        AWVALID = 1; AWADDR = 32'h4; WVALID = 1; WDATA = 32'h1; WSTRB = 4'hF;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 1; ARADDR = 32'h4;
        tick();
        ARVALID = 0;
        model_write(32'h4, 32'h1, 4'hF);
        chk("collide bvalid", 512'(BVALID), 512'(1));
        chk("collide rvalid", 512'(RVALID), 512'(1));
        chk("collide rdata old", 512'(RDATA), 512'(old1));
        chk("collide regs", regs_o, model_flat());
        chk("collide pulse", 512'(wr_pulse_o), 512'(16'h0002));
        BREADY = 1; RREADY = 1;
        tick();
        BREADY = 0; RREADY = 0;
        chk("collide done", 512'({BVALID, RVALID}), 512'(0));
        axi_read(32'h4, 0, 0, 32'h1, 2'b00, "collide reread");

        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          in_range(a) ? 2'b00 : 2'b11, $sformatf("rnd%0d_wr", i));
            end else begin
                read_model(a, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d_rd", i));
            end
        end

        // Reset with AW latched and W still pending must leave nothing behind.
        AWVALID = 1; AWADDR = 32'h8;
        tick();
        AWVALID = 0;
        chk("midreset aw latched", 512'({AWREADY, WREADY}), 512'(2'b01));
        ARESET = 1;
        #2;
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
        chk("midreset regs", regs_o, 512'(0));
        chk("midreset outs", 512'({AWREADY, WREADY, BVALID}), 512'(0));
        tick();
        ARESET = 0;
        tick();
        chk("midreset readies", 512'({AWREADY, WREADY, ARREADY}), 512'(3'b111));
        axi_write(32'hC, 32'hCAFEF00D, 4'hF, 4, 0, 0, 2'b00, "post_reset");
        read_model(32'h8, 0, 0, "post_reset reg2");
        read_model(32'hC, 0, 0, "post_reset reg3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
